id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU.
- Latches decoded operands and control from decode on each clock.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble per stall cycle.
- Drives the ALU's in1/in2/sel plus the control and store data carried to MEM.

Parameters:
- DATA_W, 16: datapath width.
- REG_ADDR_W, 3: register-file address width; register 0 reads as zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_ADDR_W  source and destination register addresses.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_alu_sel  in  4  ALU op code (same encoding as ALU sel).
- id_use_imm  in  1  in2 takes immediate instead of rt.
- id_mem_read, id_mem_write, id_reg_write  in  1  control bits.
- exm_reg_write  in  1  EX/MEM instruction writes a register.
- exm_rd_addr  in  REG_ADDR_W  EX/MEM destination address.
- exm_result  in  DATA_W  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB instruction writes a register.
- wb_rd_addr  in  REG_ADDR_W  MEM/WB destination address.
- wb_data  in  DATA_W  MEM/WB write-back data.
- flush  in  1  taken branch; kill the instruction entering EX.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- alu_in1, alu_in2  out  DATA_W  forwarded ALU operands (combinational from registered state).
- alu_sel  out  4  registered ALU op.
- ex_valid  out  1  EX holds a real instruction.
- ex_rd_addr  out  REG_ADDR_W  registered destination.
- ex_mem_read, ex_mem_write, ex_reg_write  out  1  registered control, forced 0 on bubble.
- ex_store_data  out  DATA_W  forwarded rt value for sw.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state: all registers clear to 0, so ex_valid=0, all control bits 0, alu_sel=4'b0000, stored data and addresses 0.
  - This gives alu_in1=alu_in2=ex_store_data=0 and id_stall=0.
  - Reset mid-operation drops the in-flight instruction at once.
- Registered fields: ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_rs_data, ex_rt_data, ex_imm, alu_sel, ex_use_imm, control bits, ex_valid.
- Load-use hazard, load_use = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (match_rs | match_rt):
  - match_rs: ex_rd_addr==id_rs_addr.
  - match_rt: ex_rd_addr==id_rt_addr & (!id_use_imm | id_mem_write).
- id_stall = load_use & !flush.
- Per-edge update, in priority order:
  - flush: ex_valid and all control bits <= 0; data fields don't-care.
  - else load_use: bubble, same as flush; decode holds its instruction via id_stall.
  - else: capture all id_* fields; ex_valid <= id_valid; control bits <= id_* & id_valid.
- Latency: an operand is captured at edge N and presented to the ALU in the cycle after edge N; no other delay.
- Forwarding (per source, separately for rs and rt, evaluated on registered addresses):
  - Address 0: use registered data; no forwarding, and the value is forced to 0.
  - exm_reg_write & exm_rd_addr==addr: use exm_result. EX/MEM has priority.
  - else wb_reg_write & wb_rd_addr==addr: use wb_data.
  - else: use registered read data.
- Operand outputs:
  - alu_in1 = fwd_rs.
  - alu_in2 = ex_use_imm ? ex_imm : fwd_rt.
  - ex_store_data = fwd_rt.
- Forwarding is combinational and is not gated by ex_valid; on a bubble the outputs are don't-care beyond control being 0.
- Simultaneous flush and load_use: flush wins; id_stall=0; bubble inserted.
- Back-to-back stalls are allowed. Each cycle with load_use true inserts one bubble. In practice this is one cycle, since the load advances out of EX.

Test Plan:
- Reset: assert rst_n=0 mid-stream with ex_valid=1 -> at once ex_valid=0, ex_reg_write=0, alu_sel=0, alu_in1=alu_in2=0, id_stall=0.
- Plain capture: id add, rs_data=16'h0005, rt_data=16'h0003, sel=0000, no matches -> next cycle alu_in1=5, alu_in2=3, ex_valid=1.
- Double forward: rs=r2, exm_rd=r2 with exm_result=16'h00AA, wb_rd=r2 with wb_data=16'h0055 -> alu_in1=16'h00AA; clear exm_reg_write -> alu_in1=16'h0055.
- Register zero: rs=r0, exm_rd=r0, exm_reg_write=1, exm_result=16'hFFFF -> alu_in1=0.
- Load-use: EX holds lw r3; ID holds add r4,r3,r1 -> id_stall=1 one cycle; next cycle ex_valid=0; after that add is captured with r3 forwarded from wb_data.
- Flush priority: flush=1 together with a load-use condition -> id_stall=0; next cycle ex_valid=0 and ex_mem_write=0. Also check addi with id_use_imm=1, imm=16'hFFFE -> alu_in2=16'hFFFE and no stall on rt.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bus: decoded instruction and forwarding sources in, ALU operands
// and EX-stage control out.
interface id_ex_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [3:0]            id_alu_sel;
    logic                  id_use_imm;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_reg_write;
    logic                  exm_reg_write;
    logic [REG_ADDR_W-1:0] exm_rd_addr;
    logic [DATA_W-1:0]     exm_result;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;

    logic                  id_stall;
    logic [DATA_W-1:0]     alu_in1;
    logic [DATA_W-1:0]     alu_in2;
    logic [3:0]            alu_sel;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_reg_write;
    logic [DATA_W-1:0]     ex_store_data;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
               id_imm, id_alu_sel, id_use_imm, id_mem_read, id_mem_write, id_reg_write,
               exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_data,
               flush,
        input  id_stall, alu_in1, alu_in2, alu_sel, ex_valid, ex_rd_addr,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_store_data
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
               id_imm, id_alu_sel, id_use_imm, id_mem_read, id_mem_write, id_reg_write,
               exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_data,
               flush,
        output id_stall, alu_in1, alu_in2, alu_sel, ex_valid, ex_rd_addr,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use bubble insertion.

// One forwarding mux per source operand; EX/MEM beats MEM/WB, r0 is always zero.
module id_ex_fwd #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0]     exm_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     fwd_data
);
    always_comb begin
        fwd_data = reg_data;
        if (addr == '0)
            fwd_data = '0;
        else if (exm_reg_write && (exm_rd_addr == addr))
            fwd_data = exm_result;
        else if (wb_reg_write && (wb_rd_addr == addr))
            fwd_data = wb_data;
    end
endmodule

module id_ex_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    localparam int NUM_SRC = 2;  // index 0 = rs, 1 = rt

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [3:0]            alu_sel;
        logic                  use_imm;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;

    logic match_rs;
    logic match_rt;
    logic load_use;

    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0][DATA_W-1:0]     src_data;
    logic [NUM_SRC-1:0][DATA_W-1:0]     fwd_data;

    // rt only matters to the load when it is actually read: as an ALU operand
    // or as store data.
    always_comb begin
        match_rs = (ex_q.rd_addr == bus.id_rs_addr);
        match_rt = (ex_q.rd_addr == bus.id_rt_addr) && (!bus.id_use_imm || bus.id_mem_write);
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                   bus.id_valid && (match_rs || match_rt);
    end

    assign bus.id_stall = load_use && !bus.flush;

    always_comb begin
        ex_d           = ex_q;
        ex_d.valid     = bus.id_valid;
        ex_d.rs_addr   = bus.id_rs_addr;
        ex_d.rt_addr   = bus.id_rt_addr;
        ex_d.rd_addr   = bus.id_rd_addr;
        ex_d.rs_data   = bus.id_rs_data;
        ex_d.rt_data   = bus.id_rt_data;
        ex_d.imm       = bus.id_imm;
        ex_d.alu_sel   = bus.id_alu_sel;
        ex_d.use_imm   = bus.id_use_imm;
        ex_d.mem_read  = bus.id_mem_read  && bus.id_valid;
        ex_d.mem_write = bus.id_mem_write && bus.id_valid;
        ex_d.reg_write = bus.id_reg_write && bus.id_valid;
    end

    // Flush and load-use both leave a bubble; data fields just hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush || load_use) begin
            ex_q.valid     <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
            ex_q.reg_write <= 1'b0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign src_addr[0] = ex_q.rs_addr;
    assign src_addr[1] = ex_q.rt_addr;
    assign src_data[0] = ex_q.rs_data;
    assign src_data[1] = ex_q.rt_data;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        id_ex_fwd #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_fwd (
            .addr          (src_addr[i]),
            .reg_data      (src_data[i]),
            .exm_reg_write (bus.exm_reg_write),
            .exm_rd_addr   (bus.exm_rd_addr),
            .exm_result    (bus.exm_result),
            .wb_reg_write  (bus.wb_reg_write),
            .wb_rd_addr    (bus.wb_rd_addr),
            .wb_data       (bus.wb_data),
            .fwd_data      (fwd_data[i])
        );
    end

    assign bus.alu_in1       = fwd_data[0];
    assign bus.alu_in2       = ex_q.use_imm ? ex_q.imm : fwd_data[1];
    assign bus.ex_store_data = fwd_data[1];
    assign bus.alu_sel       = ex_q.alu_sel;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_reg_write  = ex_q.reg_write;
endmodule
